adc_scan_ctrl: RTL and testbench
================================

Name: adc_scan_ctrl

Overview:
- Sequences conversions on the board ADC interface. Each conversion is a start/done handshake to the serial ADC driver; each result is forwarded as one sample.
- Triggered by single-cycle ticks from push-button edge detectors:
  - one button fires a single sweep over the enabled channels;
  - another button toggles continuous scanning with a programmable inter-sweep gap.
- Sits between the button edge detectors and the ADC serial driver; feeds samples to the display/storage logic.

Parameters:
- N_CH, 8, number of ADC channels (channel index width CH_W = clog2(N_CH)).
- DATA_W, 12, ADC sample width.
- PERIOD_W, 24, width of the inter-sweep gap counter.
- TIMEOUT, 4096, max cycles to wait for adc_done before aborting.

Ports:
- clk  in  1  system clock from PLL
- reset_n  in  1  asynchronous active-low reset
- tick_single  in  1  one-cycle pulse: request one sweep
- tick_cont  in  1  one-cycle pulse: toggle continuous mode
- ch_mask  in  N_CH  enabled channels, bit i = channel i
- period  in  PERIOD_W  idle cycles between continuous sweeps
- adc_start  out  1  one-cycle conversion request to ADC driver
- adc_ch  out  CH_W  channel for the current conversion; held stable from adc_start until adc_done
- adc_done  in  1  one-cycle pulse: conversion finished, adc_data valid
- adc_data  in  DATA_W  conversion result
- sample_valid  out  1  one-cycle pulse: new sample
- sample_ch  out  CH_W  channel of the sample
- sample_data  out  DATA_W  sample value
- cont_active  out  1  continuous mode enabled
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  sticky: a conversion timed out
- req_dropped  out  1  one-cycle pulse: tick_single ignored

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, internal counters 0, latched mask 0.
- States:
  - IDLE
  - ISSUE: adc_start=1 for exactly this one cycle.
  - WAIT: wait for adc_done.
  - NEXT: select the next channel.
  - HOLD: inter-sweep gap.
- IDLE:
  - tick_cont toggles cont_active. If the result is 1, latch ch_mask and begin a sweep.
  - Otherwise, tick_single latches ch_mask and begins a sweep.
  - Both ticks in the same cycle: tick_cont wins; tick_single is dropped and req_dropped pulses.
- Sweep start:
  - Latched mask != 0: cur_ch = lowest set bit; go to ISSUE.
  - Latched mask == 0: no conversion. Go to HOLD if cont_active, else stay in IDLE.
- ISSUE -> WAIT after 1 cycle; adc_ch = cur_ch.
- WAIT:
  - On adc_done, register adc_data/cur_ch into sample_data/sample_ch; sample_valid=1 on the next cycle (1-cycle latency from adc_done); go to NEXT.
  - After TIMEOUT cycles with no adc_done: set err_timeout, clear cont_active, go to IDLE with no sample. err_timeout clears only on reset.
- NEXT (1 cycle):
  - Next set bit above cur_ch in the latched mask exists: cur_ch = that bit; go to ISSUE.
  - Else, cont_active: go to HOLD.
  - Else: go to IDLE.
- Channel order: ascending; no wrap within a sweep; cur_ch = N_CH-1 always ends the sweep.
- HOLD:
  - Loads the gap counter with period on entry and counts down.
  - At 0 (period==0: immediately on the next cycle), relatch ch_mask and start a new sweep.
  - If cont_active is cleared while in HOLD, go to IDLE the next cycle.
- During a sweep or HOLD:
  - tick_single is ignored and req_dropped pulses.
  - tick_cont clears cont_active (it cannot set it). The current sweep completes, then the block goes to IDLE.
- ch_mask changes mid-sweep have no effect until the next latch.
- adc_done outside WAIT is ignored.
- Reset asserted mid-conversion: immediate return to reset values; a late adc_done after reset release is ignored (IDLE).

Decomposition:
- Shared package adc_pkg:
  - state encoding localparams (IDLE, ISSUE, WAIT, NEXT, HOLD);
  - N_CH and DATA_W defaults, shared with the ADC driver.
- One sub-module: adc_next_ch, a combinational priority finder. Inputs are mask and cur_ch plus a first flag; outputs are the next channel index and a found flag. It is reused for both the sweep-start and NEXT lookups.

Test Plan:
- Single sweep: ch_mask=8'b1010_0101, tick_single; driver answers adc_done 20 cycles after each adc_start with data=0x100+ch -> adc_ch sequence 0,2,5,7; four sample_valid pulses with data 0x100,0x102,0x105,0x107; then IDLE, busy=0.
- Continuous: mask=8'h03, period=10, tick_cont -> cont_active=1. Gap from sample_valid of ch1 to the next adc_start = NEXT(1)+period(10)+relatch/ISSUE cycles, exactly as specified. A second tick_cont mid-sweep -> the sweep finishes (ch1 sampled), then IDLE with cont_active=0.
- Simultaneous tick_single+tick_cont in IDLE -> cont_active=1, req_dropped=1 for one cycle, one sweep started. tick_single during WAIT -> req_dropped pulse, no extra conversion.
- Timeout: TIMEOUT=64, never assert adc_done -> err_timeout=1 at 64 cycles after ISSUE, cont_active=0, IDLE, no sample_valid.
- mask=0: tick_single -> no adc_start, stays IDLE. mask=0 in continuous -> cycles through HOLD only. mask=8'h80 -> exactly one conversion on ch7.
- Reset pulse in WAIT, then a late adc_done -> all outputs 0, no sample_valid, IDLE.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC scan controller and the serial ADC driver:
// FSM state encoding, default channel count and sample width.
package adc_pkg;

  localparam int N_CH_DEF   = 8;
  localparam int DATA_W_DEF = 12;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_ISSUE = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [ST_W-1:0] ST_NEXT  = 3'd3;
  localparam logic [ST_W-1:0] ST_HOLD  = 3'd4;

  // Channel index width; a single-channel build still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_next_ch.sv
// Combinational priority finder: lowest enabled channel (first=1) or the
// lowest enabled channel strictly above cur_ch (first=0).
module adc_next_ch
  import adc_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] mask,
  input  logic [CH_W-1:0] cur_ch,
  input  logic            first,
  output logic [CH_W-1:0] nxt_ch,
  output logic            found
);

  logic [N_CH-1:0] cand_s;

  // Candidate channels, then pick the lowest by scanning downwards.
  always_comb begin
    cand_s = {N_CH{1'b0}};
    nxt_ch = {CH_W{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      cand_s[i] = mask[i] & (first | (CH_W'(i) > cur_ch));
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      nxt_ch = cand_s[i] ? CH_W'(i) : nxt_ch;
    end
    found = |cand_s;
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Button-driven ADC sweep sequencer: issues start/done conversions over the
// enabled channels, once or continuously with a programmable gap.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PERIOD_W = 24,
  parameter int TIMEOUT  = 4096,
  localparam int CH_W    = ch_width(N_CH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick_single,
  input  logic                tick_cont,
  input  logic [N_CH-1:0]     ch_mask,
  input  logic [PERIOD_W-1:0] period,
  output logic                adc_start,
  output logic [CH_W-1:0]     adc_ch,
  input  logic                adc_done,
  input  logic [DATA_W-1:0]   adc_data,
  output logic                sample_valid,
  output logic [CH_W-1:0]     sample_ch,
  output logic [DATA_W-1:0]   sample_data,
  output logic                cont_active,
  output logic                busy,
  output logic                err_timeout,
  output logic                req_dropped
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [ST_W-1:0]     state_q, state_d;
  logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
  logic [N_CH-1:0]     mask_q, mask_d;
  logic [PERIOD_W-1:0] gap_q, gap_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                cont_q, cont_d;
  logic                err_q, err_d;
  logic                drop_q, drop_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                sv_q, sv_d;
  logic [CH_W-1:0]     sch_q, sch_d;
  logic [DATA_W-1:0]   sdata_q, sdata_d;

  logic                sweep_go_s;
  logic                first_s;
  logic [N_CH-1:0]     fmask_s;
  logic [CH_W-1:0]     nxt_ch_s;
  logic                found_s;

  // One finder serves both lookups: a sweep start searches the live ch_mask
  // (the value being latched), NEXT searches the latched mask above cur_ch.
  assign first_s = (state_q != ST_NEXT);
  assign fmask_s = first_s ? ch_mask : mask_q;

  adc_next_ch #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_next_ch (
    .mask   (fmask_s),
    .cur_ch (cur_ch_q),
    .first  (first_s),
    .nxt_ch (nxt_ch_s),
    .found  (found_s)
  );

  // Next-state and output computation for the sweep sequencer.
  always_comb begin
    state_d    = state_q;
    cur_ch_d   = cur_ch_q;
    mask_d     = mask_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    cont_d     = cont_q;
    err_d      = err_q;
    drop_d     = 1'b0;
    sv_d       = 1'b0;
    sch_d      = sch_q;
    sdata_d    = sdata_q;
    sweep_go_s = 1'b0;

    // Outside IDLE a tick_cont can only stop continuous mode.
    if (state_q == ST_IDLE) begin
      if (tick_cont) begin
        cont_d     = ~cont_q;
        sweep_go_s = ~cont_q;
        drop_d     = tick_single;
      end else begin
        sweep_go_s = tick_single;
      end
    end else begin
      drop_d = tick_single;
      cont_d = cont_q & ~tick_cont;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        tmo_d   = TMO_W'(1);
      end
      ST_WAIT: begin
        if (adc_done) begin
          sv_d    = 1'b1;
          sch_d   = cur_ch_q;
          sdata_d = adc_data;
          state_d = ST_NEXT;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          cont_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_NEXT: begin
        if (found_s) begin
          cur_ch_d = nxt_ch_s;
          state_d  = ST_ISSUE;
        end else if (cont_d) begin
          gap_d   = period;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!cont_d) begin
          state_d = ST_IDLE;
        end else if (gap_q == {PERIOD_W{1'b0}}) begin
          sweep_go_s = 1'b1;
        end else begin
          gap_d = gap_q - PERIOD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An empty mask skips straight to the gap (or back to IDLE).
    if (sweep_go_s) begin
      mask_d = ch_mask;
      if (found_s) begin
        cur_ch_d = nxt_ch_s;
        state_d  = ST_ISSUE;
      end else if (cont_d) begin
        gap_d   = period;
        state_d = ST_HOLD;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      mask_d = mask_q;
    end

    start_d = (state_d == ST_ISSUE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cur_ch_q <= {CH_W{1'b0}};
      mask_q   <= {N_CH{1'b0}};
      gap_q    <= {PERIOD_W{1'b0}};
      tmo_q    <= {TMO_W{1'b0}};
      cont_q   <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      sv_q     <= 1'b0;
      sch_q    <= {CH_W{1'b0}};
      sdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      mask_q   <= mask_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
      cont_q   <= cont_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      sv_q     <= sv_d;
      sch_q    <= sch_d;
      sdata_q  <= sdata_d;
    end
  end

  assign adc_start    = start_q;
  assign adc_ch       = cur_ch_q;
  assign sample_valid = sv_q;
  assign sample_ch    = sch_q;
  assign sample_data  = sdata_q;
  assign cont_active  = cont_q;
  assign busy         = busy_q;
  assign err_timeout  = err_q;
  assign req_dropped  = drop_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl: a set-bit reference model queues the
// expected conversions/samples, an ADC responder answers starts, a monitor checks.
module tb_adc_scan_ctrl;

  localparam int CH_W = 3;

  logic        clk;
  logic        reset_n;
  logic        tick_single, tick_cont;
  logic [7:0]  ch_mask;
  logic [23:0] period;
  logic        adc_start;
  logic [CH_W-1:0] adc_ch;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        sample_valid;
  logic [CH_W-1:0] sample_ch;
  logic [11:0] sample_data;
  logic        cont_active, busy, err_timeout, req_dropped;

  adc_scan_ctrl #(.N_CH(8), .DATA_W(12), .PERIOD_W(24), .TIMEOUT(64)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick_single  (tick_single),
    .tick_cont    (tick_cont),
    .ch_mask      (ch_mask),
    .period       (period),
    .adc_start    (adc_start),
    .adc_ch       (adc_ch),
    .adc_done     (adc_done),
    .adc_data     (adc_data),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data),
    .cont_active  (cont_active),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .req_dropped  (req_dropped)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int drop_exp  = 0;
  int drop_seen = 0;
  int exp_conv[$];
  int exp_samp[$];
  logic [11:0] drv_data[$];
  bit drv_en    = 1'b1;
  bit drv_fixed = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    n_total++;
    $display("FAIL %s", name);
  endtask

  // Reference model: a sweep converts every set bit of the mask, ascending.
  task automatic push_sweep(input logic [7:0] m);
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        exp_conv.push_back(i);
        exp_samp.push_back(i);
      end
    end
  endtask

  task automatic check_zero(input string name);
    chk(name, {8'd0, adc_start, adc_ch, sample_valid, sample_ch, sample_data,
               cont_active, busy, err_timeout, req_dropped}, 32'd0);
  endtask

  task automatic pulse(input logic s, input logic c);
    @(negedge clk);
    tick_single = s;
    tick_cont   = c;
    @(negedge clk);
    tick_single = 1'b0;
    tick_cont   = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input int max_c, output int at);
    at = -1;
    for (int k = 0; k < max_c; k++) begin
      if (adc_start) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) bound_fail("wait_start: no adc_start within bound");
  endtask

  task automatic wait_idle(input int max_c);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < max_c; k++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) bound_fail("wait_idle: busy never dropped");
  endtask

  // ADC driver model: answers each start after a fixed or random delay.
  initial begin : responder
    int d;
    logic [11:0] dat;
    adc_done = 1'b0;
    adc_data = 12'd0;
    forever begin
      @(negedge clk);
      if (adc_start && drv_en && reset_n) begin
        d   = drv_fixed ? 20 : int'($urandom_range(1, 30));
        dat = drv_fixed ? (12'h100 + 12'(adc_ch)) : 12'($urandom);
        repeat (d) @(negedge clk);
        adc_done = 1'b1;
        adc_data = dat;
        drv_data.push_back(dat);
        @(negedge clk);
        adc_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin : monitor
    int e;
    logic [11:0] dv;
    if (reset_n) begin
      if (adc_start) begin
        if (exp_conv.size() == 0) bound_fail($sformatf("unexpected adc_start ch=%0d", adc_ch));
        else begin
          e = exp_conv.pop_front();
          chk("adc_ch", 32'(adc_ch), 32'(e));
        end
      end
      if (sample_valid) begin
        if (exp_samp.size() == 0 || drv_data.size() == 0)
          bound_fail($sformatf("unexpected sample_valid ch=%0d", sample_ch));
        else begin
          e  = exp_samp.pop_front();
          dv = drv_data.pop_front();
          chk("sample_ch", 32'(sample_ch), 32'(e));
          chk("sample_data", 32'(sample_data), 32'(dv));
        end
      end
      if (req_dropped) drop_seen++;
    end
  end

  initial begin : stim
    int at, t0;
    bit found;
    logic [7:0] m;
    reset_n = 1'b0; tick_single = 1'b0; tick_cont = 1'b0;
    ch_mask = 8'd0; period = 24'd0;
    wait_cyc(3);
    check_zero("reset outputs");
    reset_n = 1'b1;
    wait_cyc(1);
    check_zero("idle after reset");

    // Single sweep 0,2,5,7 with data 0x100+ch; a tick_single during WAIT is dropped.
    drv_fixed = 1'b1;
    ch_mask = 8'hA5;
    push_sweep(8'hA5);
    pulse(1'b1, 1'b0);
    chk("t1 busy", 32'(busy), 32'd1);
    wait_start(10, at);
    wait_cyc(3);
    drop_exp++;
    pulse(1'b1, 1'b0);
    wait_idle(2000);
    chk("t1 queues empty", 32'(exp_conv.size() + exp_samp.size()), 32'd0);
    chk("t1 drops", 32'(drop_seen), 32'(drop_exp));

    // Continuous: mask 0x03, period 10; three sweeps then stop mid-sweep.
    ch_mask = 8'h03;
    period  = 24'd10;
    repeat (3) push_sweep(8'h03);
    pulse(1'b0, 1'b1);
    chk("t2 cont_active set", 32'(cont_active), 32'd1);
    found = 1'b0;
    t0 = 0;
    for (int k = 0; k < 300; k++) begin
      if (sample_valid && sample_ch == 3'd1) begin
        found = 1'b1;
        t0 = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!found) bound_fail("t2: no ch1 sample");
    @(negedge clk);
    wait_start(100, at);
    // sample_valid shows during NEXT, HOLD spans period+1 cycles, then ISSUE.
    chk("t2 gap sample->start", 32'(at - t0), 32'(10 + 2));
    found = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (exp_conv.size() == 1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) bound_fail("t2: third sweep did not start");
    pulse(1'b0, 1'b1);
    chk("t2 cont cleared", 32'(cont_active), 32'd0);
    chk("t2 sweep still busy", 32'(busy), 32'd1);
    wait_idle(500);
    chk("t2 queues empty", 32'(exp_conv.size() + exp_samp.size()), 32'd0);

    // Both ticks together: continuous wins, single dropped, one sweep then HOLD.
    drv_fixed = 1'b0;
    m = 8'($urandom_range(1, 255));
    ch_mask = m;
    period = 24'd200;
    push_sweep(m);
    drop_exp++;
    pulse(1'b1, 1'b1);
    chk("t3 cont_active set", 32'(cont_active), 32'd1);
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (exp_samp.size() == 0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) bound_fail("t3: sweep did not finish");
    wait_cyc(3);
    chk("t3 busy in gap", 32'(busy), 32'd1);
    pulse(1'b0, 1'b1);
    chk("t3 idle after stop", 32'(busy), 32'd0);
    chk("t3 cont cleared", 32'(cont_active), 32'd0);
    chk("t3 drops", 32'(drop_seen), 32'(drop_exp));

    // Empty mask: single sweep does nothing; continuous only cycles the gap.
    ch_mask = 8'h00;
    pulse(1'b1, 1'b0);
    chk("t4 single mask0 idle", 32'(busy), 32'd0);
    wait_cyc(5);
    chk("t4 still idle", 32'(busy), 32'd0);
    period = 24'd3;
    pulse(1'b0, 1'b1);
    chk("t4 cont mask0 active", 32'(cont_active), 32'd1);
    wait_cyc(40);
    chk("t4 cont mask0 busy", 32'(busy), 32'd1);
    pulse(1'b0, 1'b1);
    chk("t4 stop busy", 32'(busy), 32'd0);
    chk("t4 stop cont", 32'(cont_active), 32'd0);

    // Top channel only.
    ch_mask = 8'h80;
    push_sweep(8'h80);
    pulse(1'b1, 1'b0);
    wait_idle(200);
    chk("t5 queues empty", 32'(exp_conv.size() + exp_samp.size()), 32'd0);

    // Random single sweeps; ch_mask is scrambled right after the latch.
    for (int it = 0; it < 8; it++) begin
      m = 8'($urandom);
      ch_mask = m;
      push_sweep(m);
      pulse(1'b1, 1'b0);
      ch_mask = 8'($urandom);
      wait_idle(2000);
      chk("t6 queues empty", 32'(exp_conv.size() + exp_samp.size()), 32'd0);
    end

    // Timeout in continuous mode: no adc_done ever arrives.
    drv_en = 1'b0;
    ch_mask = 8'h10;
    period = 24'd5;
    exp_conv.push_back(4);
    pulse(1'b0, 1'b1);
    wait_start(10, at);
    while (cyc < at + 63) @(negedge clk);
    chk("t7 err before limit", 32'(err_timeout), 32'd0);
    chk("t7 busy before limit", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t7 err at limit", 32'(err_timeout), 32'd1);
    chk("t7 idle at limit", 32'(busy), 32'd0);
    chk("t7 cont cleared", 32'(cont_active), 32'd0);
    wait_cyc(10);
    chk("t7 err sticky", 32'(err_timeout), 32'd1);
    chk("t7 queues empty", 32'(exp_conv.size() + exp_samp.size()), 32'd0);
    drv_en = 1'b1;

    // Reset during WAIT; the responder's done then arrives after release.
    drv_fixed = 1'b1;
    ch_mask = 8'h01;
    exp_conv.push_back(0);
    pulse(1'b1, 1'b0);
    wait_start(10, at);
    wait_cyc(5);
    reset_n = 1'b0;
    wait_cyc(2);
    check_zero("t8 outputs in reset");
    reset_n = 1'b1;
    wait_cyc(30);
    check_zero("t8 after late done");
    drv_data.delete();

    chk("final queues empty", 32'(exp_conv.size() + exp_samp.size()), 32'd0);
    chk("final drops", 32'(drop_seen), 32'(drop_exp));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
